// File: rtl/rv32_exec_regfile_core_pkg.sv
// Shared widths and execute-unit encodings for the RV32 execute/register-file slice.
package rv32_exec_regfile_core_pkg;

    localparam int unsigned CPU_WIDTH     = 32;
    localparam int unsigned EXU_OPT_WIDTH = 4;
    localparam int unsigned EXU_SEL_WIDTH = 2;
    localparam int unsigned GPR_ADDR_W    = 5;

    typedef enum logic [EXU_OPT_WIDTH-1:0] {
        ExuAdd   = 4'd0,
        ExuSub   = 4'd1,
        ExuSll   = 4'd2,
        ExuSlt   = 4'd3,
        ExuSltu  = 4'd4,
        ExuXor   = 4'd5,
        ExuSrl   = 4'd6,
        ExuSra   = 4'd7,
        ExuOr    = 4'd8,
        ExuAnd   = 4'd9,
        ExuPassB = 4'd10
    } exu_op_e;

    typedef enum logic [EXU_SEL_WIDTH-1:0] {
        SelRs1Rs2 = 2'd0,
        SelRs1Imm = 2'd1,
        SelPcImm  = 2'd2,
        SelPc4    = 2'd3
    } exu_sel_e;

endpackage

// File: rtl/rv32_rstn_sync.sv
// Reset synchroniser: asserts asynchronously, releases after Stages rising clock edges.
module rv32_rstn_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_sync_no
);

    logic [Stages-1:0] sync_d, sync_q;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = 1'b1;
        for (int unsigned i = 1; i < Stages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_no = sync_q[Stages-1];

endmodule

// File: rtl/rv32_exec_regfile_core.sv
// RV32 execute slice: reset synchroniser, 32-entry GPR file and combinational ALU.
// Optional GPR_BYPASS_EN: same-cycle write-through from the write port to both read ports.
module rv32_exec_regfile_core
    import rv32_exec_regfile_core_pkg::*;
#(
    parameter int unsigned CPU_WIDTH   = rv32_exec_regfile_core_pkg::CPU_WIDTH,
    parameter int unsigned RSTN_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 rstn_sync,
    input  logic                 wr_en_Rd,
    input  logic [4:0]           addr_Rd,
    input  logic [CPU_WIDTH-1:0] data_Rd,
    input  logic [4:0]           addr_Rs1,
    input  logic [4:0]           addr_Rs2,
    output logic [CPU_WIDTH-1:0] data_Rs1,
    output logic [CPU_WIDTH-1:0] data_Rs2,
    input  logic [CPU_WIDTH-1:0] pc,
    input  logic [CPU_WIDTH-1:0] imm,
    input  logic [3:0]           exu_opt_code,
    input  logic [1:0]           exu_sel_code,
    output logic [CPU_WIDTH-1:0] exu_res
);

    rv32_rstn_sync #(
        .Stages (RSTN_STAGES)
    ) u_rstn_sync (
        .clk_i       (clk),
        .rst_ni      (rstn),
        .rst_sync_no (rstn_sync)
    );

    // x0 has no storage; it is hardwired to zero on the read side.
    logic [CPU_WIDTH-1:0] regs_q [1:31];

    always_ff @(posedge clk or negedge rstn_sync) begin
        if (!rstn_sync) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_Rd && (addr_Rd != 5'd0)) begin
            regs_q[addr_Rd] <= data_Rd;
        end
    end

    always_comb begin
        data_Rs1 = '0;
        data_Rs2 = '0;
        if (addr_Rs1 != 5'd0) begin
            data_Rs1 = regs_q[addr_Rs1];
        end
        if (addr_Rs2 != 5'd0) begin
            data_Rs2 = regs_q[addr_Rs2];
        end
`ifdef GPR_BYPASS_EN
        // Non-zero address check above already excludes x0 from the bypass.
        if (wr_en_Rd && rstn_sync && (addr_Rs1 != 5'd0) && (addr_Rs1 == addr_Rd)) begin
            data_Rs1 = data_Rd;
        end
        if (wr_en_Rd && rstn_sync && (addr_Rs2 != 5'd0) && (addr_Rs2 == addr_Rd)) begin
            data_Rs2 = data_Rd;
        end
`endif
    end

    logic [CPU_WIDTH-1:0] op_a, op_b;
    logic [4:0]           shamt;

    always_comb begin
        case (exu_sel_e'(exu_sel_code))
            SelRs1Rs2: begin op_a = data_Rs1; op_b = data_Rs2; end
            SelRs1Imm: begin op_a = data_Rs1; op_b = imm;      end
            SelPcImm:  begin op_a = pc;       op_b = imm;      end
            default:   begin op_a = pc;       op_b = CPU_WIDTH'(4); end
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        exu_res = '0;
        case (exu_op_e'(exu_opt_code))
            ExuAdd:   exu_res = op_a + op_b;
            ExuSub:   exu_res = op_a - op_b;
            ExuSll:   exu_res = op_a << shamt;
            ExuSlt:   exu_res = {{(CPU_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ExuSltu:  exu_res = {{(CPU_WIDTH-1){1'b0}}, op_a < op_b};
            ExuXor:   exu_res = op_a ^ op_b;
            ExuSrl:   exu_res = op_a >> shamt;
            ExuSra:   exu_res = $unsigned($signed(op_a) >>> shamt);
            ExuOr:    exu_res = op_a | op_b;
            ExuAnd:   exu_res = op_a & op_b;
            ExuPassB: exu_res = op_b;
            default:  exu_res = '0;
        endcase
    end

endmodule

// File: tb/tb_rv32_exec_regfile_core.sv
// Scoreboard bench for rv32_exec_regfile_core: directed plan items then random traffic.
module tb_rv32_exec_regfile_core;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rstn_sync;
    logic        wr_en_Rd;
    logic [4:0]  addr_Rd, addr_Rs1, addr_Rs2;
    logic [31:0] data_Rd, data_Rs1, data_Rs2, pc, imm, exu_res;
    logic [3:0]  exu_opt_code;
    logic [1:0]  exu_sel_code;

    rv32_exec_regfile_core #(
        .CPU_WIDTH   (32),
        .RSTN_STAGES (STAGES)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rstn_sync    (rstn_sync),
        .wr_en_Rd     (wr_en_Rd),
        .addr_Rd      (addr_Rd),
        .data_Rd      (data_Rd),
        .addr_Rs1     (addr_Rs1),
        .addr_Rs2     (addr_Rs2),
        .data_Rs1     (data_Rs1),
        .data_Rs2     (data_Rs2),
        .pc           (pc),
        .imm          (imm),
        .exu_opt_code (exu_opt_code),
        .exu_sel_code (exu_sel_code),
        .exu_res      (exu_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        sync;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference state: architectural registers plus edges seen since rstn went high.
    logic [31:0] mregs [32];
    int          edge_cnt = 0;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h want %h", tag, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.tag, "rstn_sync", {31'd0, rstn_sync}, {31'd0, e.sync});
            chk(e.tag, "data_Rs1", data_Rs1, e.rs1);
            chk(e.tag, "data_Rs2", data_Rs2, e.rs2);
            chk(e.tag, "exu_res", exu_res, e.res);
        end
    end

    task automatic step(input logic r, input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] pcv, input logic [31:0] immv,
                        input logic [3:0] op, input logic [1:0] sel, input string tag);
        exp_t        e;
        logic        sync_now;
        logic [31:0] a, b;
        @(posedge clk);
        #1;
        rstn = r; wr_en_Rd = we; addr_Rd = rd; data_Rd = d;
        addr_Rs1 = s1; addr_Rs2 = s2; pc = pcv; imm = immv;
        exu_opt_code = op; exu_sel_code = sel;

        if (!r) edge_cnt = 0;
        sync_now = (edge_cnt >= STAGES);
        if (!sync_now) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end
        e.tag  = tag;
        e.sync = sync_now;
        e.rs1  = mregs[s1];
        e.rs2  = mregs[s2];
`ifdef GPR_BYPASS_EN
        if (we && sync_now && rd != 0 && s1 == rd) e.rs1 = d;
        if (we && sync_now && rd != 0 && s2 == rd) e.rs2 = d;
`endif
        case (sel)
            2'd0:    begin a = e.rs1; b = e.rs2; end
            2'd1:    begin a = e.rs1; b = immv;  end
            2'd2:    begin a = pcv;   b = immv;  end
            default: begin a = pcv;   b = 32'd4; end
        endcase
        e.res = alu_ref(op, a, b);
        sb_q.push_back(e);

        // Effect of the coming rising edge.
        if (r) begin
            if (sync_now && we && rd != 0) mregs[rd] = d;
            if (edge_cnt < STAGES) edge_cnt++;
        end
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        step(1'b1, 1'b1, rd, d, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 2'd0, "write");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        rstn = 1'b0; wr_en_Rd = 1'b0; addr_Rd = '0; data_Rd = '0;
        addr_Rs1 = '0; addr_Rs2 = '0; pc = '0; imm = '0;
        exu_opt_code = '0; exu_sel_code = '0;

        step(1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 0, 0, 4'd0, 2'd0, "rst_hold_wr");
        step(1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd0, 0, 0, 4'd0, 2'd0, "rst_hold_rd");
        step(1'b1, 1'b0, 5'd0, 0, 5'd5, 5'd0, 0, 0, 4'd0, 2'd0, "rst_release");
        step(1'b1, 1'b0, 5'd0, 0, 5'd5, 5'd0, 0, 0, 4'd0, 2'd0, "rst_edge1");
        step(1'b1, 1'b0, 5'd0, 0, 5'd5, 5'd0, 0, 0, 4'd0, 2'd0, "rst_edge2");

        wr(5'd0, 32'hDEADBEEF);
        wr(5'd7, 32'h12345678);
        step(1'b1, 1'b0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 2'd0, "x0_read");
        step(1'b1, 1'b0, 5'd0, 0, 5'd7, 5'd7, 0, 0, 4'd0, 2'd0, "x7_both");
        step(1'b1, 1'b1, 5'd7, 32'hAAAA5555, 5'd7, 5'd7, 0, 0, 4'd0, 2'd0, "x7_same_cyc");
        step(1'b1, 1'b0, 5'd0, 0, 5'd7, 5'd0, 0, 0, 4'd0, 2'd0, "x7_after");

        wr(5'd1, 32'h7FFFFFFF);
        wr(5'd2, 32'h00000001);
        wr(5'd3, 32'h00000000);
        wr(5'd4, 32'hFFFFFFFF);
        wr(5'd6, 32'h80000000);
        wr(5'd8, 32'h00000001);
        step(1'b1, 1'b0, 0, 0, 5'd1, 5'd2, 0, 0, 4'd0, 2'd0, "add_ovf");
        step(1'b1, 1'b0, 0, 0, 5'd3, 5'd2, 0, 0, 4'd1, 2'd0, "sub_wrap");
        step(1'b1, 1'b0, 0, 0, 5'd4, 5'd2, 0, 0, 4'd3, 2'd0, "slt");
        step(1'b1, 1'b0, 0, 0, 5'd4, 5'd2, 0, 0, 4'd4, 2'd0, "sltu");
        step(1'b1, 1'b0, 0, 0, 5'd6, 5'd0, 0, 32'h24, 4'd6, 2'd1, "srl");
        step(1'b1, 1'b0, 0, 0, 5'd6, 5'd0, 0, 32'h24, 4'd7, 2'd1, "sra");
        step(1'b1, 1'b0, 0, 0, 5'd8, 5'd0, 0, 32'h24, 4'd2, 2'd1, "sll");
        step(1'b1, 1'b0, 0, 0, 5'd0, 5'd0, 32'h80000000, 32'h0, 4'd0, 2'd3, "pc_plus4");
        step(1'b1, 1'b0, 0, 0, 5'd0, 5'd0, 32'h80000000, 32'hFFFFFFFC, 4'd0, 2'd2, "pc_imm");
        step(1'b1, 1'b0, 0, 0, 5'd1, 5'd0, 0, 32'h12345000, 4'd10, 2'd1, "pass_b");
        step(1'b1, 1'b0, 0, 0, 5'd1, 5'd4, 32'h1234, 32'h5678, 4'd13, 2'd0, "reserved");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] iv;
            iv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom;
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, iv,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "random");
        end

        step(1'b0, 1'b0, 0, 0, 5'd1, 5'd7, 0, 0, 4'd0, 2'd0, "midrun_rst");
        step(1'b1, 1'b0, 0, 0, 5'd4, 5'd6, 0, 0, 4'd0, 2'd0, "midrun_rel");
        step(1'b1, 1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd8, 0, 0, 4'd0, 2'd0, "midrun_edge1");
        step(1'b1, 1'b1, 5'd9, 32'h0F0F0F0F, 5'd9, 5'd1, 0, 0, 4'd0, 2'd0, "midrun_edge2");
        step(1'b1, 1'b0, 0, 0, 5'd9, 5'd9, 0, 0, 4'd5, 2'd0, "midrun_after");

        for (int n = 0; n < 60; n++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "random2");
        end

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
